// File: rtl/masked_gadget_pkg.sv
// rtl/masked_gadget_pkg.sv - shared share-index helpers and cross-term schedule for masked gadgets
// Purpose: legal parameter ranges, mod-NSHARES index arithmetic and the
//          per-stage product schedule used by the masked AND pipeline.
// Ports:   none (package).
package masked_gadget_pkg;

    localparam int NSHARES_MIN = 2;
    localparam int NSHARES_MAX = 8;
    localparam int WIDTH_MIN   = 1;

    typedef struct packed {
        logic [3:0] a_idx;
        logic [3:0] b_idx;
    } term_t;

    function automatic int share_add(input int n, input int i, input int k);
        return (i + k) % n;
    endfunction

    // Stage t of an n-share gadget adds a[a_idx] & b[b_idx] into column i.
    // t in 1..n-1 are cross terms, t >= n is the diagonal. Odd stages pair
    // a_i with a b share ahead of it, even stages pair b_i with an a share
    // ahead of it, so every off-diagonal product lands in exactly one column.
    function automatic term_t term_idx(input int n, input int t, input int i);
        term_t r;
        if (t >= n) begin
            r.a_idx = 4'(i);
            r.b_idx = 4'(i);
        end else if ((t % 2) == 1) begin
            r.a_idx = 4'(i);
            r.b_idx = 4'(share_add(n, i, (t + 1) / 2));
        end else begin
            r.a_idx = 4'(share_add(n, i, t / 2));
            r.b_idx = 4'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/masked_and_stage.sv
// rtl/masked_and_stage.sv - one pipeline stage of the masked AND gadget
// Purpose: registers the operand copies and NSHARES columns, adding the
//          product selected by stage index T into each column.
// Ports:   clk, rst_n (async, active-low), adv (stage enable),
//          a_d/b_d/col_d registered inputs from the previous stage,
//          a_q/b_q/col_q registered outputs to the next stage.
module masked_and_stage
    import masked_gadget_pkg::*;
#(
    parameter int NSHARES = 3,
    parameter int WIDTH   = 1,
    parameter int T       = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       adv,
    input  logic [NSHARES*WIDTH-1:0]   a_d,
    input  logic [NSHARES*WIDTH-1:0]   b_d,
    input  logic [NSHARES*WIDTH-1:0]   col_d,
    output logic [NSHARES*WIDTH-1:0]   a_q,
    output logic [NSHARES*WIDTH-1:0]   b_q,
    output logic [NSHARES*WIDTH-1:0]   col_q
);

    logic [NSHARES*WIDTH-1:0] col_nxt;

    for (genvar i = 0; i < NSHARES; i++) begin : g_col
        localparam term_t TI = term_idx(NSHARES, T, i);
        localparam int    AI = int'(TI.a_idx);
        localparam int    BI = int'(TI.b_idx);
        assign col_nxt[i*WIDTH +: WIDTH] = col_d[i*WIDTH +: WIDTH]
            ^ (a_d[AI*WIDTH +: WIDTH] & b_d[BI*WIDTH +: WIDTH]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            col_q <= '0;
        end else if (adv) begin
            a_q   <= a_d;
            b_q   <= b_d;
            col_q <= col_nxt;
        end
    end

endmodule

// File: rtl/masked_and_pipe.sv
// rtl/masked_and_pipe.sv - pipelined NSHARES-share masked AND over WIDTH lanes
// Purpose: q = a & b in shared form; capture stage folds rand_in into a
//          zero-sum mask, then NSHARES-1 cross stages and one diagonal stage.
// Ports:   clk, rst_n (async, active-low), in_valid/in_ready, a_sh, b_sh,
//          rand_in, out_valid/out_ready, q_sh.
module masked_and_pipe
    import masked_gadget_pkg::*;
#(
    parameter int NSHARES = 3,
    parameter int WIDTH   = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NSHARES*WIDTH-1:0]       a_sh,
    input  logic [NSHARES*WIDTH-1:0]       b_sh,
    input  logic [(NSHARES-1)*WIDTH-1:0]   rand_in,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NSHARES*WIDTH-1:0]       q_sh
);

    localparam int SW = NSHARES * WIDTH;

    logic            adv;
    logic [SW-1:0]   mask;
    logic [WIDTH-1:0] mask_last;
    logic [SW-1:0]   a_c, b_c, col_c;
    logic [NSHARES:0] v;

    logic [SW-1:0]   a_p   [0:NSHARES-1];
    logic [SW-1:0]   b_p   [0:NSHARES-1];
    logic [SW-1:0]   col_p [0:NSHARES];
    logic [SW-1:0]   a_unused, b_unused;

    // Whole-pipe stall: nothing moves while a result waits downstream.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Last mask word is the XOR of all fresh words, so the masks sum to zero.
    always_comb begin
        mask      = '0;
        mask_last = '0;
        for (int j = 0; j < NSHARES - 1; j++) begin
            mask[j*WIDTH +: WIDTH] = rand_in[j*WIDTH +: WIDTH];
            mask_last              = mask_last ^ rand_in[j*WIDTH +: WIDTH];
        end
        mask[(NSHARES-1)*WIDTH +: WIDTH] = mask_last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_c   <= '0;
            b_c   <= '0;
            col_c <= '0;
            v     <= '0;
        end else if (adv) begin
            a_c   <= a_sh;
            b_c   <= b_sh;
            col_c <= mask;
            v     <= {v[NSHARES-1:0], in_valid};
        end
    end

    assign a_p[0]   = a_c;
    assign b_p[0]   = b_c;
    assign col_p[0] = col_c;

    for (genvar t = 1; t <= NSHARES; t++) begin : g_stage
        if (t < NSHARES) begin : g_cross
            masked_and_stage #(.NSHARES(NSHARES), .WIDTH(WIDTH), .T(t)) u_stage (
                .clk   (clk),
                .rst_n (rst_n),
                .adv   (adv),
                .a_d   (a_p[t-1]),
                .b_d   (b_p[t-1]),
                .col_d (col_p[t-1]),
                .a_q   (a_p[t]),
                .b_q   (b_p[t]),
                .col_q (col_p[t])
            );
        end else begin : g_diag
            // Operands are not needed past the diagonal stage.
            masked_and_stage #(.NSHARES(NSHARES), .WIDTH(WIDTH), .T(t)) u_stage (
                .clk   (clk),
                .rst_n (rst_n),
                .adv   (adv),
                .a_d   (a_p[t-1]),
                .b_d   (b_p[t-1]),
                .col_d (col_p[t-1]),
                .a_q   (a_unused),
                .b_q   (b_unused),
                .col_q (col_p[t])
            );
        end
    end

    assign out_valid = v[NSHARES];
    assign q_sh      = col_p[NSHARES];

endmodule

// File: tb/tb_masked_and_pipe.sv
// tb/tb_masked_and_pipe.sv - directed self-checking bench for masked_and_pipe
module tb_masked_and_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // NSHARES=3 WIDTH=1
    logic       iv3 = 0, ir3, ov3, or3 = 1;
    logic [2:0] a3 = 0, b3 = 0, q3;
    logic [1:0] r3 = 0;
    // NSHARES=4 WIDTH=8
    logic        iv4 = 0, ir4, ov4;
    logic [31:0] a4 = 0, b4 = 0, q4;
    logic [23:0] r4 = 0;
    // NSHARES=2 WIDTH=4
    logic       iv2 = 0, ir2, ov2;
    logic [7:0] a2 = 0, b2 = 0, q2;
    logic [3:0] r2 = 0;

    masked_and_pipe #(.NSHARES(3), .WIDTH(1)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv3), .in_ready(ir3), .a_sh(a3), .b_sh(b3),
        .rand_in(r3), .out_valid(ov3), .out_ready(or3), .q_sh(q3));
    masked_and_pipe #(.NSHARES(4), .WIDTH(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a_sh(a4), .b_sh(b4),
        .rand_in(r4), .out_valid(ov4), .out_ready(1'b1), .q_sh(q4));
    masked_and_pipe #(.NSHARES(2), .WIDTH(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .a_sh(a2), .b_sh(b2),
        .rand_in(r2), .out_valid(ov2), .out_ready(1'b1), .q_sh(q2));

    int n_cmp = 0;
    int n_bad = 0;
    logic [2:0] got_q[$];
    logic       exp_q[$];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) if (rst_n && ov3 && or3) got_q.push_back(q3);

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send3(input logic [2:0] a, input logic [2:0] b, input logic [1:0] r);
        logic rdy;
        bit   ok = 0;
        a3 = a; b3 = b; r3 = r; iv3 = 1;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk); rdy = ir3;
            @(posedge clk); #1;
            if (rdy) ok = 1;
        end
        if (!ok) check_eq("send_timeout", 0, 1);
        exp_q.push_back((^a) & (^b));
        iv3 = 0;
    endtask

    task automatic drain_compare(input string tag);
        for (int k = 0; k < 400 && got_q.size() < exp_q.size(); k++) @(negedge clk);
        repeat (6) @(negedge clk);
        check_eq({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check_eq($sformatf("%s_xor%0d", tag, i), ^got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
        @(posedge clk); #1;
    endtask

    // Single op into an empty pipe: out_valid must rise on the 4th edge.
    task automatic lat_check3(input string tag, input logic [2:0] a, input logic [2:0] b,
                              input logic [1:0] r, output logic [2:0] q);
        a3 = a; b3 = b; r3 = r; iv3 = 1;
        @(posedge clk); #1; iv3 = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq($sformatf("%s_early%0d", tag, k), ov3, 0);
        end
        @(negedge clk);
        check_eq({tag, "_valid"}, ov3, 1);
        check_eq({tag, "_xor"}, ^q3, (^a) & (^b));
        q = q3;
        @(posedge clk); #1;
        got_q.delete();
        exp_q.delete();
    endtask

    function automatic logic [7:0] fold4(input logic [31:0] x);
        return x[7:0] ^ x[15:8] ^ x[23:16] ^ x[31:24];
    endfunction
    function automatic logic [3:0] fold2(input logic [7:0] x);
        return x[3:0] ^ x[7:4];
    endfunction

    task automatic run4(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [23:0] r);
        int lat = -1;
        a4 = a; b4 = b; r4 = r; iv4 = 1;
        @(posedge clk); #1; iv4 = 0;
        for (int k = 0; k < 12 && lat < 0; k++) begin
            @(negedge clk);
            if (ov4) lat = k;
        end
        check_eq({tag, "_lat"}, lat, 4);
        check_eq({tag, "_xor"}, fold4(q4), fold4(a) & fold4(b));
        if (a == 0 && b == 0 && r == 0) check_eq({tag, "_zero"}, q4, 0);
        @(posedge clk); #1;
    endtask

    task automatic run2(input string tag, input logic [7:0] a, input logic [7:0] b, input logic [3:0] r);
        int lat = -1;
        a2 = a; b2 = b; r2 = r; iv2 = 1;
        @(posedge clk); #1; iv2 = 0;
        for (int k = 0; k < 12 && lat < 0; k++) begin
            @(negedge clk);
            if (ov2) lat = k;
        end
        check_eq({tag, "_lat"}, lat, 2);
        check_eq({tag, "_xor"}, fold2(q2), fold2(a) & fold2(b));
        if (a == 0 && b == 0 && r == 0) check_eq({tag, "_zero"}, q2, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [2:0] q, q_ref, q_hold;
        logic [2:0] m;

        // Reset state
        #1;
        check_eq("rst_out_valid", ov3, 0);
        check_eq("rst_q_sh", q3, 0);
        check_eq("rst_in_ready", ir3, 1);
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;

        // 1: hand-computed vector
        lat_check3("t1", 3'b001, 3'b110, 2'b11, q);
        check_eq("t1_q_sh", q, 3'b110);

        // 2: exhaustive back-to-back
        or3 = 1;
        for (int a = 0; a < 8; a++)
            for (int b = 0; b < 8; b++)
                for (int r = 0; r < 4; r++)
                    send3(3'(a), 3'(b), 2'(r));
        drain_compare("t2");

        // 3: stall with 3 in flight
        or3 = 0;
        send3(3'b111, 3'b001, 2'b01);
        send3(3'b110, 3'b011, 2'b10);
        send3(3'b100, 3'b100, 2'b11);
        for (int k = 0; k < 20 && !ov3; k++) @(negedge clk);
        check_eq("t3_first_valid", ov3, 1);
        q_hold = q3;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_eq($sformatf("t3_in_ready%0d", k), ir3, 0);
            check_eq($sformatf("t3_hold%0d", k), q3, q_hold);
        end
        @(posedge clk); #1;
        or3 = 1;
        drain_compare("t3");

        // 4: async reset with pipe full
        for (int k = 0; k < 4; k++) send3(3'(k + 3), 3'(7 - k), 2'(k));
        #1 rst_n = 0;
        #1;
        check_eq("t4_out_valid", ov3, 0);
        check_eq("t4_q_sh", q3, 0);
        check_eq("t4_in_ready", ir3, 1);
        @(posedge clk); #1;
        rst_n = 1;
        got_q.delete();
        exp_q.delete();
        @(posedge clk); #1;
        lat_check3("t4_after", 3'b001, 3'b110, 2'b11, q);
        check_eq("t4_after_q_sh", q, 3'b110);

        // 6: fixed a,b; q shares move by exactly the mask {r0^r1, r1, r0}
        lat_check3("t6_r0", 3'b100, 3'b010, 2'b00, q_ref);
        for (int r = 1; r < 4; r++) begin
            m = {r[0] ^ r[1], r[1], r[0]};
            lat_check3($sformatf("t6_r%0d", r), 3'b100, 3'b010, 2'(r), q);
            check_eq($sformatf("t6_mask%0d", r), q ^ q_ref, m);
        end

        // 5: other configurations
        run4("t5_n4_zero", 32'h0, 32'h0, 24'h0);
        run2("t5_n2_zero", 8'h0, 8'h0, 4'h0);
        for (int k = 0; k < 6; k++) begin
            run4($sformatf("t5_n4_%0d", k), $urandom, $urandom, 24'($urandom));
            run2($sformatf("t5_n2_%0d", k), 8'($urandom), 8'($urandom), 4'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
